// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front-end between the MEM pipeline stage and a 16-bit,
// big-endian, byte-addressed data memory. One request is handled at a time.
// Byte and halfword operations are turned into aligned halfword accesses.
// A byte store is done as read-modify-write, because the memory always
// writes both bytes of a halfword. Load data is byte-selected and
// sign/zero-extended. Every accepted request gets a single-cycle response,
// and that response carries an error flag.
//
// Big-endian lane mapping: the even byte address lives in data[15:8] and the
// odd byte address lives in data[7:0].
//
// Parameters:
//   ADDR_W     request/memory address width
//   MEM_BYTES  memory size in bytes; byte addresses >= MEM_BYTES are errors
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/ready    request handshake; ready is high only while idle
//   req_write          1 = store, 0 = load
//   req_byte           1 = byte access, 0 = halfword access
//   req_signed         byte load: 1 = sign-extend, 0 = zero-extend
//   req_addr           byte address
//   req_wdata          store data (byte store uses [7:0])
//   resp_valid         one-cycle completion pulse
//   resp_err           misaligned or out-of-range access (with resp_valid)
//   resp_data          load result; 0 for stores and errors
//   mem_read/mem_write memory strobes (never both high)
//   mem_addr           memory halfword address (always even)
//   mem_wdata          memory write data
//   mem_rdata          memory read data, valid the cycle after mem_read
//
// Optional feature (macro MAU_FAULT_CAPTURE_EN):
//   fault_clr          clears the fault flag and the captured address
//   fault_flag         sticky; set whenever an erroneous request is accepted
//   fault_addr         first faulting req_addr seen while fault_flag was 0
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [15:0]       resp_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
`ifdef MAU_FAULT_CAPTURE_EN
    ,
    input  logic              fault_clr,
    output logic              fault_flag,
    output logic [ADDR_W-1:0] fault_addr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    // One extra bit keeps the range compare exact when MEM_BYTES == 2**ADDR_W.
    localparam logic [ADDR_W:0] LP_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t              r_state;
    state_t              w_state_next;

    // Request fields latched at acceptance.
    logic                r_write;
    logic                r_byte;
    logic                r_signed;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;

    // The merged halfword that a byte store writes back.
    logic [15:0]         r_merge;

    logic                r_resp_valid;
    logic                r_resp_err;
    logic [15:0]         r_resp_data;

    logic                w_addr_oor;
    logic                w_misalign;
    logic                w_req_err;
    logic                w_accept;
    logic                w_start;
    logic                w_err_accept;
    logic [7:0]          w_sel_byte;
    logic [15:0]         w_load_data;
    logic [15:0]         w_merge;

    // ------------------------------------------------------------------
    // Acceptance and error classification (only meaningful in IDLE)
    // ------------------------------------------------------------------
    assign w_addr_oor   = ({1'b0, req_addr} >= LP_MEM_LIMIT);
    assign w_misalign   = ~req_byte & req_addr[0];
    assign w_req_err    = w_addr_oor | w_misalign;
    assign w_accept     = req_valid & (r_state == ST_IDLE);
    assign w_start      = w_accept & ~w_req_err;
    assign w_err_accept = w_accept & w_req_err;

    // ------------------------------------------------------------------
    // Load formatting: pick the addressed byte lane and extend it.
    // ------------------------------------------------------------------
    assign w_sel_byte  = r_addr[0] ? mem_rdata[7:0] : mem_rdata[15:8];
    assign w_load_data = r_byte ? {{8{w_sel_byte[7] & r_signed}}, w_sel_byte}
                                : mem_rdata;

    // ------------------------------------------------------------------
    // Byte-store merge. Each lane takes the new byte when it is the
    // addressed lane. Otherwise it keeps the byte just read from memory.
    // Lane 0 ([7:0]) is the odd address. Lane 1 ([15:8]) is the even one.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            localparam logic LP_ODD_LANE = (gi == 0) ? 1'b1 : 1'b0;
            assign w_merge[gi*8 +: 8] = (r_addr[0] == LP_ODD_LANE)
                                        ? r_wdata[7:0]
                                        : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and memory-side outputs. The memory strobes decode
    // only from the state and the latched request. This gives no
    // combinational path from req_* to mem_*.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = {r_addr[ADDR_W-1:1], 1'b0};
        mem_wdata    = 16'h0000;

        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_start) begin
                    // Only a halfword store can skip the read. A byte store
                    // needs the other byte of the halfword first.
                    if (req_write && !req_byte) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_read     = 1'b1;
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_next = r_write ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
                mem_write    = 1'b1;
                mem_wdata    = r_byte ? r_merge : r_wdata;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, merge register and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 16'h0000;
            r_merge      <= 16'h0000;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 16'h0000;
        end else begin
            // The response is a pulse. Its registers clear unless they are set below.
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 16'h0000;

            if (w_start) begin
                r_write  <= req_write;
                r_byte   <= req_byte;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end

            // An erroneous request is answered at its acceptance edge.
            // It never reaches memory.
            if (w_err_accept) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
            end

            case (r_state)
                ST_CAPTURE: begin
                    if (!r_write) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_load_data;
                    end else begin
                        r_merge <= w_merge;
                    end
                end
                ST_WRITE: begin
                    r_resp_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_resp_data;

`ifdef MAU_FAULT_CAPTURE_EN
    // ------------------------------------------------------------------
    // Sticky fault capture. A new error has priority over a clear in the
    // same cycle. In that case the flag stays set and the new address
    // replaces the old one.
    // ------------------------------------------------------------------
    logic              r_fault_flag;
    logic [ADDR_W-1:0] r_fault_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_flag <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_err_accept) begin
            r_fault_flag <= 1'b1;
            if (!r_fault_flag || fault_clr) begin
                r_fault_addr <= req_addr;
            end
        end else if (fault_clr) begin
            r_fault_flag <= 1'b0;
            r_fault_addr <= '0;
        end
    end

    assign fault_flag = r_fault_flag;
    assign fault_addr = r_fault_addr;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// Testbench for mem_access_unit.
//
// The bench drives directed scenarios, then a randomized request stream. A
// byte-array reference model of memory gives the expected load data, error
// status, latency and memory traffic for each request. A separate behavioural
// memory device sits on the mem_* ports, so data really goes through the DUT.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int ADDR_W    = 16;
    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [15:0] resp_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef MAU_FAULT_CAPTURE_EN
    logic        fault_clr;
    logic        fault_flag;
    logic [15:0] fault_addr;
`endif

    logic        preload;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;

    logic [7:0]  dev_mem [0:MEM_BYTES-1];   // memory device on the bus
    logic [7:0]  ref_mem [0:MEM_BYTES-1];   // reference model contents

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MAU_FAULT_CAPTURE_EN
        ,
        .fault_clr  (fault_clr),
        .fault_flag (fault_flag),
        .fault_addr (fault_addr)
`endif
    );

    // Big-endian 16-bit memory. Read data appears the cycle after mem_read.
    // A write commits only at an edge where mem_write is high.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_BYTES; i++) dev_mem[i] <= 8'(i);
        end else begin
            if (mem_read)
                mem_rdata <= {dev_mem[mem_addr[9:0]], dev_mem[{mem_addr[9:1], 1'b1}]};
            if (mem_write) begin
                dev_mem[{mem_addr[9:1], 1'b0}] <= mem_wdata[15:8];
                dev_mem[{mem_addr[9:1], 1'b1}] <= mem_wdata[7:0];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its response. The task expects to
    // be called away from a clock edge while the DUT is idle. It returns at
    // posedge+1 of the response cycle, so an immediate next call gets
    // accepted back-to-back.
    task automatic run_req(input string tag, input bit w, input bit b, input bit s,
                           input logic [15:0] a, input logic [15:0] wd,
                           output logic [15:0] got);
        bit          e;
        int          lat, lat_exp, reads, writes, rdy_busy, idx;
        bit          both;
        logic [15:0] rd_a, wr_a, wr_d, d_exp, wr_d_exp, ea;
        logic [7:0]  bsel;

        // Reference expectations from the access rules.
        idx      = int'(a);
        e        = (idx >= MEM_BYTES) || (!b && a[0]);
        ea       = {a[15:1], 1'b0};
        d_exp    = 16'h0000;
        wr_d_exp = 16'h0000;
        if (e)           lat_exp = 1;
        else if (!w)     lat_exp = 3;
        else if (b)      lat_exp = 4;
        else             lat_exp = 2;
        if (!e && !w) begin
            if (b) begin
                bsel  = ref_mem[idx];
                d_exp = {(s && bsel[7]) ? 8'hFF : 8'h00, bsel};
            end else begin
                d_exp = {ref_mem[idx], ref_mem[idx+1]};
            end
        end
        if (!e && w) begin
            if (!b)        wr_d_exp = wd;
            else if (a[0]) wr_d_exp = {ref_mem[idx-1], wd[7:0]};
            else           wr_d_exp = {wd[7:0], ref_mem[idx+1]};
        end

        check_val({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the request after acceptance. The DUT must ignore it.
        req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_signed = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);

        lat = 1; reads = 0; writes = 0; both = 0; rdy_busy = 0;
        rd_a = 16'h0; wr_a = 16'h0; wr_d = 16'h0;
        while (1) begin
            if (mem_read)  begin reads++;  rd_a = mem_addr; end
            if (mem_write) begin writes++; wr_a = mem_addr; wr_d = mem_wdata; end
            if (mem_read && mem_write) both = 1;
            if (resp_valid || lat >= 12) break;
            if (req_ready) rdy_busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        got = resp_data;

        check_val({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        check_val({tag, ".err"}, 32'(resp_err), 32'(e));
        check_val({tag, ".data"}, 32'(resp_data), 32'(d_exp));
        check_val({tag, ".reads"}, 32'(reads), (e || (w && !b)) ? 32'd0 : 32'd1);
        check_val({tag, ".writes"}, 32'(writes), (!e && w) ? 32'd1 : 32'd0);
        check_val({tag, ".rd_wr_overlap"}, 32'(both), 32'd0);
        if (!e) check_val({tag, ".ready_busy"}, 32'(rdy_busy), 32'd0);
        if (reads > 0)  check_val({tag, ".rd_addr"}, 32'(rd_a), 32'(ea));
        if (writes > 0) begin
            check_val({tag, ".wr_addr"}, 32'(wr_a), 32'(ea));
            check_val({tag, ".wr_data"}, 32'(wr_d), 32'(wr_d_exp));
        end

        if (!e && w) begin
            if (b) begin
                ref_mem[idx] = wd[7:0];
            end else begin
                ref_mem[idx]   = wd[15:8];
                ref_mem[idx+1] = wd[7:0];
            end
        end

        n_txn++;
        $display("txn %0d %s w=%0d b=%0d s=%0d addr=0x%04h wdata=0x%04h -> err=%0d data=0x%04h lat=%0d",
                 n_txn, tag, w, b, s, a, wd, resp_err, resp_data, lat);
    endtask

    initial begin
        logic [15:0] got;
        int          seen;

        rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
`ifdef MAU_FAULT_CAPTURE_EN
        fault_clr = 1'b0;
`endif
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i);

        #2;
        check_val("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst.resp_err",   32'(resp_err),   32'd0);
        check_val("rst.resp_data",  32'(resp_data),  32'd0);
        check_val("rst.mem_read",   32'(mem_read),   32'd0);
        check_val("rst.mem_write",  32'(mem_write),  32'd0);
        check_val("rst.mem_addr",   32'(mem_addr),   32'd0);
        check_val("rst.mem_wdata",  32'(mem_wdata),  32'd0);
`ifdef MAU_FAULT_CAPTURE_EN
        check_val("rst.fault_flag", 32'(fault_flag), 32'd0);
        check_val("rst.fault_addr", 32'(fault_addr), 32'd0);
`endif
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed loads
        run_req("hw_load_0010", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, got);
        check_val("hw_load_0010.value", 32'(got), 32'h1011);
        run_req("b_load_s_0085", 1'b0, 1'b1, 1'b1, 16'h0085, 16'h0, got);
        check_val("b_load_s_0085.value", 32'(got), 32'hFF85);
        run_req("b_load_u_0085", 1'b0, 1'b1, 1'b0, 16'h0085, 16'h0, got);
        check_val("b_load_u_0085.value", 32'(got), 32'h0085);
        run_req("b_load_s_0084", 1'b0, 1'b1, 1'b1, 16'h0084, 16'h0, got);
        check_val("b_load_s_0084.value", 32'(got), 32'hFF84);

        // Byte store read-modify-write
        run_req("b_store_0021", 1'b1, 1'b1, 1'b0, 16'h0021, 16'h00AB, got);
        run_req("hw_load_0020", 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, got);
        check_val("hw_load_0020.value", 32'(got), 32'h20AB);

        // Error cases
        run_req("err_misalign_0013", 1'b0, 1'b0, 1'b0, 16'h0013, 16'h0, got);
        run_req("err_oor_0400", 1'b1, 1'b0, 1'b0, 16'h0400, 16'hBEEF, got);
        run_req("err_oor_byte_03FF_ok", 1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0, got);
        check_val("byte_03FF.value", 32'(got), 32'h00FF);
`ifdef MAU_FAULT_CAPTURE_EN
        check_val("fault.flag_set", 32'(fault_flag), 32'd1);
        check_val("fault.addr_first", 32'(fault_addr), 32'h0013);
        fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        check_val("fault.flag_clr", 32'(fault_flag), 32'd0);
        check_val("fault.addr_clr", 32'(fault_addr), 32'd0);
`endif

        // Reset during CAPTURE of a byte store
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 16'h0030; req_wdata = 16'h00CD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("midrst.resp_valid", 32'(resp_valid), 32'd0);
        check_val("midrst.mem_read",   32'(mem_read),   32'd0);
        check_val("midrst.mem_write",  32'(mem_write),  32'd0);
        check_val("midrst.mem_addr",   32'(mem_addr),   32'd0);
        check_val("midrst.mem_wdata",  32'(mem_wdata),  32'd0);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (mem_write || resp_valid) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_write || resp_valid) seen++;
        end
        check_val("midrst.no_activity", 32'(seen), 32'd0);
        run_req("hw_load_0030", 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0, got);
        check_val("hw_load_0030.value", 32'(got), 32'h3031);

        // Back-to-back: the load is accepted in the store's response cycle
        run_req("hw_store_0040", 1'b1, 1'b0, 1'b0, 16'h0040, 16'h1234, got);
        run_req("hw_load_0040", 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, got);
        check_val("hw_load_0040.value", 32'(got), 32'h1234);

        // Randomized stream against the reference model
        for (int t = 0; t < 150; t++) begin
            logic [15:0] ra;
            if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
            else                           ra = 16'($urandom_range(0, MEM_BYTES-1));
            run_req("rnd", 1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
